// File: rtl/slot_reel_ctrl.sv
// slot_reel_ctrl: start -> spin -> per-reel stop -> judge sequencer for three
// mod-8 reels sharing one spin-speed prescaler. All outputs are registered.
// Optional feature macro: SLOT_AUTOSTOP_EN (spin timeout after AUTO_TICKS ticks).
module slot_reel_ctrl #(
    parameter int DIV        = 4,
    parameter int AUTO_TICKS = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] stop,
    output logic [8:0] pos,
    output logic [2:0] spinning,
    output logic [1:0] state,
    output logic       done,
    output logic       win,
    output logic [2:0] win_sym
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SPIN  = 2'b01,
        JUDGE = 2'b10,
        BAD   = 2'b11
    } state_t;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t      st, st_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [2:0]  spin_nx;
    logic [8:0]  pos_nx;
    logic        done_nx, win_nx;
    logic [2:0]  sym_nx;
    logic        tick, auto_stop, all_eq;

    assign state  = st;
    assign tick   = (st == SPIN) && (presc == PW'(DIV - 1));
    assign all_eq = (pos[2:0] == pos[5:3]) && (pos[5:3] == pos[8:6]);

`ifdef SLOT_AUTOSTOP_EN
    localparam int TW = $clog2(AUTO_TICKS + 1);
    logic [TW-1:0] tick_cnt;

    // Ticks since the spin began; held at zero outside SPIN so entry starts clean
    always_ff @(posedge clock) begin
        if (reset)
            tick_cnt <= '0;
        else if (st != SPIN)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= tick_cnt + 1'b1;
    end

    // The AUTO_TICKS-th tick stops every reel instead of stepping it
    assign auto_stop = tick && (tick_cnt == TW'(AUTO_TICKS - 1));
`else
    // No timeout hardware; AUTO_TICKS >= 2 so this is a constant zero
    assign auto_stop = (AUTO_TICKS < 0);
`endif

    // Next-state and next-output computation; every target defaulted to hold
    always_comb begin
        st_nx    = st;
        spin_nx  = spinning;
        pos_nx   = pos;
        presc_nx = presc;
        done_nx  = 1'b0;
        win_nx   = win;
        sym_nx   = win_sym;
        case (st)
            IDLE: begin
                if (start) begin
                    st_nx    = SPIN;
                    spin_nx  = 3'b111;
                    presc_nx = '0;
                    win_nx   = 1'b0;
                    sym_nx   = 3'b000;
                end
            end
            SPIN: begin
                presc_nx = tick ? '0 : presc + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    // A stop on the tick cycle wins: the reel halts without stepping
                    if (spinning[i] && (stop[i] || auto_stop))
                        spin_nx[i] = 1'b0;
                    else if (spinning[i] && tick)
                        pos_nx[3*i +: 3] = pos[3*i +: 3] + 3'd1;
                end
                if (spin_nx == 3'b000)
                    st_nx = JUDGE;
            end
            JUDGE: begin
                win_nx  = all_eq;
                sym_nx  = all_eq ? pos[2:0] : 3'b000;
                done_nx = 1'b1;
                st_nx   = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= IDLE;
            pos      <= '0;
            spinning <= '0;
            presc    <= '0;
            done     <= 1'b0;
            win      <= 1'b0;
            win_sym  <= 3'b000;
        end else begin
            st       <= st_nx;
            pos      <= pos_nx;
            spinning <= spin_nx;
            presc    <= presc_nx;
            done     <= done_nx;
            win      <= win_nx;
            win_sym  <= sym_nx;
        end
    end

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Self-checking bench for slot_reel_ctrl. Expected reel positions are derived
// arithmetically from stop times (ticks land every DIV cycles after start).
module tb_slot_reel_ctrl;

    localparam int DIV  = 4;
    localparam int AUTO = 16;
`ifdef SLOT_AUTOSTOP_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, start;
    logic [2:0] stop;
    logic [8:0] pos;
    logic [2:0] spinning;
    logic [1:0] state;
    logic       done, win;
    logic [2:0] win_sym;

    int total = 0;
    int bad   = 0;
    int m_pos[3];

    slot_reel_ctrl #(.DIV(DIV), .AUTO_TICKS(AUTO)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .pos(pos), .spinning(spinning), .state(state),
        .done(done), .win(win), .win_sym(win_sym)
    );

    always #5 clock = ~clock;

    // Ticks that moved a reel stopped at edge s, observed after edge c
    function automatic int steps(input int s, input int c);
        int a, b;
        a = c / DIV;
        b = (s - 1) / DIV;
        return (a < b) ? a : b;
    endfunction

    // One spin: start at edge 0, reel i stop raised from edge s_i for hold edges
    task automatic run_spin(input int s0, input int s1, input int s2,
                            input int hold, input bit junk, input bit b2b);
        int sin[3], s[3], p0[3], fp[3];
        int last, c_end, n;
        bit eq;
        logic [1:0] exp_st;
        logic [2:0] exp_spin, exp_sym;
        logic [8:0] exp_pos;
        sin[0] = s0; sin[1] = s1; sin[2] = s2;
        last = 0;
        for (int i = 0; i < 3; i++) begin
            s[i] = sin[i];
            if (AUTO_EN && s[i] > AUTO * DIV) s[i] = AUTO * DIV;
            if (s[i] > last) last = s[i];
            p0[i] = m_pos[i];
            fp[i] = (p0[i] + (s[i] - 1) / DIV) % 8;
        end
        eq = (fp[0] == fp[1]) && (fp[1] == fp[2]);
        exp_sym = eq ? 3'(fp[0]) : 3'b000;
        c_end = b2b ? last + 2 : last + 3;
        start = 1'b1;
        stop  = junk ? 3'($urandom_range(0, 7)) : 3'b000;
        for (int c = 0; c <= c_end; c++) begin
            @(posedge clock); #1;
            if (b2b && c == last + 2) exp_st = 2'd1;
            else if (c < last)        exp_st = 2'd1;
            else if (c == last)       exp_st = 2'd2;
            else                      exp_st = 2'd0;
            for (int i = 0; i < 3; i++) begin
                exp_spin[i] = (b2b && c == last + 2) ? 1'b1 : (c < s[i]);
                exp_pos[3*i +: 3] = 3'((p0[i] + steps(s[i], c)) % 8);
            end
            total++;
            if (state !== exp_st) begin
                bad++; $display("FAIL spin_state c=%0d got=%0d exp=%0d", c, state, exp_st);
            end
            total++;
            if (spinning !== exp_spin) begin
                bad++; $display("FAIL spin_spinning c=%0d got=%b exp=%b", c, spinning, exp_spin);
            end
            total++;
            if (pos !== exp_pos) begin
                bad++; $display("FAIL spin_pos c=%0d got=%h exp=%h", c, pos, exp_pos);
            end
            total++;
            if (done !== (c == last + 1)) begin
                bad++; $display("FAIL spin_done c=%0d got=%b exp=%b", c, done, (c == last + 1));
            end
            if (c <= last || (b2b && c == last + 2)) begin
                total++;
                if (win !== 1'b0 || win_sym !== 3'b000) begin
                    bad++; $display("FAIL win_cleared c=%0d got=%b/%b exp=0/000", c, win, win_sym);
                end
            end else begin
                total++;
                if (win !== eq || win_sym !== exp_sym) begin
                    bad++; $display("FAIL spin_win c=%0d got=%b/%b exp=%b/%b", c, win, win_sym, eq, exp_sym);
                end
            end
            n = c + 1;
            for (int i = 0; i < 3; i++) begin
                stop[i] = (n >= sin[i] && n < sin[i] + hold);
                if (junk && n >= s[i]) stop[i] = stop[i] | 1'($urandom_range(0, 1));
            end
            start = (junk && n >= 1 && n <= last + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (b2b && (n == last + 1 || n == last + 2)) start = 1'b1;
        end
        for (int i = 0; i < 3; i++) m_pos[i] = fp[i];
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 3'b000;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (pos !== 9'd0 || spinning !== 3'b000 || state !== 2'b00) begin
            bad++; $display("FAIL reset_regs got=%h/%b/%b exp=000/000/00", pos, spinning, state);
        end
        total++;
        if (win !== 1'b0 || win_sym !== 3'b000 || done !== 1'b0) begin
            bad++; $display("FAIL reset_result got=%b/%b/%b exp=0/000/0", win, win_sym, done);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
    endtask

    task automatic test_mid_spin_reset();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        total++;
        if (spinning !== 3'b111 || pos !== 9'b010_010_010) begin
            bad++; $display("FAIL midspin_pre got=%b/%h exp=111/092", spinning, pos);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        total++;
        if (pos !== 9'd0 || spinning !== 3'b000 || state !== 2'b00 || win !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midspin_reset got=%h/%b/%b/%b/%b exp=000/000/00/0/0",
                            pos, spinning, state, win, done);
        end
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
    endtask

    task automatic test_all_stop();
        do_reset();
        run_spin(41, 41, 41, 1, 1'b0, 1'b0);
        total++;
        if (pos !== 9'b010_010_010 || win !== 1'b1 || win_sym !== 3'b010) begin
            bad++; $display("FAIL all_stop got=%h/%b/%b exp=092/1/010", pos, win, win_sym);
        end
    endtask

    task automatic test_staggered();
        do_reset();
        run_spin(14, 22, 38, 5, 1'b0, 1'b0);
        total++;
        if (pos !== 9'b001_101_011 || win !== 1'b0 || win_sym !== 3'b000) begin
            bad++; $display("FAIL staggered got=%h/%b/%b exp=06b/0/000", pos, win, win_sym);
        end
    endtask

    task automatic test_wrap_collision();
        do_reset();
        run_spin(36, 36, 36, 1, 1'b0, 1'b0);
        total++;
        if (pos !== 9'd0 || win !== 1'b1 || win_sym !== 3'b000) begin
            bad++; $display("FAIL wrap_collision got=%h/%b/%b exp=000/1/000", pos, win, win_sym);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [8:0] held;
        run_spin(10, 27, 19, 3, 1'b1, 1'b0);
        held = pos;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stop = 3'($urandom_range(1, 7));
            @(posedge clock); #1;
            total++;
            if (state !== 2'b00 || spinning !== 3'b000 || pos !== held) begin
                bad++; $display("FAIL idle_stop k=%0d got=%b/%b/%h exp=00/000/%h",
                                k, state, spinning, pos, held);
            end
        end
        stop = 3'b000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_spin(13, 13, 13, 1, 1'b0, 1'b1);
        start = 1'b0; stop = 3'b111;
        @(posedge clock); #1;
        stop = 3'b000;
        total++;
        if (state !== 2'b10 || spinning !== 3'b000) begin
            bad++; $display("FAIL b2b_judge got=%b/%b exp=10/000", state, spinning);
        end
        @(posedge clock); #1;
        total++;
        if (done !== 1'b1 || pos !== 9'b011_011_011 || win !== 1'b1 || win_sym !== 3'b011) begin
            bad++; $display("FAIL b2b_result got=%b/%h/%b/%b exp=1/0db/1/011", done, pos, win, win_sym);
        end
        @(posedge clock); #1;
        total++;
        if (done !== 1'b0 || state !== 2'b00) begin
            bad++; $display("FAIL b2b_after got=%b/%b exp=0/00", done, state);
        end
    endtask

`ifdef SLOT_AUTOSTOP_EN
    task automatic test_autostop();
        do_reset();
        run_spin(9999, 9999, 9999, 1, 1'b0, 1'b0);
        total++;
        if (pos !== 9'b111_111_111 || win !== 1'b1 || win_sym !== 3'b111) begin
            bad++; $display("FAIL autostop got=%h/%b/%b exp=1ff/1/111", pos, win, win_sym);
        end
    endtask
`endif

    task automatic test_random();
        int hi;
        hi = AUTO_EN ? 90 : 70;
        for (int k = 0; k < 8; k++)
            run_spin($urandom_range(1, hi), $urandom_range(1, hi), $urandom_range(1, hi),
                     $urandom_range(1, 4), 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 3'b000;
        test_reset();
        test_mid_spin_reset();
        test_all_stop();
        test_staggered();
        test_wrap_collision();
        test_ignored_inputs();
        test_back_to_back();
`ifdef SLOT_AUTOSTOP_EN
        test_autostop();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
